// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the logic sweep capture block: sweep FSM encoding,
// vector count and the truth-table update helper.
package logic_sweep_pkg;

    localparam int unsigned VEC_COUNT = 16;
    localparam logic [3:0]  LAST_IDX  = 4'(VEC_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } sweep_state_t;

    // Returns tt with bit idx replaced by bit_val.
    function automatic logic [15:0] tt_insert(
        input logic [15:0] tt,
        input logic [3:0]  idx,
        input logic        bit_val
    );
        logic [15:0] res;
        res      = tt;
        res[idx] = bit_val;
        return res;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Hold timer for the sweep: restarts on load, and while run is high emits a
// one-cycle expire pulse at the end of every SETTLE_CYC-cycle hold period.
module sweep_settle_timer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam logic [3:0] RELOAD      = 4'(SETTLE_CYC - 1);
    localparam logic       RELOAD_HITS = (SETTLE_CYC == 1) ? 1'b1 : 1'b0;

    logic [3:0] cnt_r;

    // Down-counter; expire is registered so it is high during the last hold cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 4'd0;
            expire <= 1'b0;
        end else if (load) begin
            cnt_r  <= RELOAD;
            expire <= RELOAD_HITS;
        end else if (run) begin
            if (expire) begin
                cnt_r  <= RELOAD;
                expire <= RELOAD_HITS;
            end else begin
                cnt_r  <= cnt_r - 4'd1;
                expire <= (cnt_r == 4'd1) ? 1'b1 : 1'b0;
            end
        end else begin
            cnt_r  <= 4'd0;
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_sweep_capture.sv
// Drives all 16 input vectors into a 4-input logic block and captures its truth
// table. Optional golden compare output enabled by LOGIC_SWEEP_COMPARE_EN.
module logic_sweep_capture
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        o,
`ifdef LOGIC_SWEEP_COMPARE_EN
    input  logic [15:0] exp_tt,
    output logic        pass,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones_count
);

    sweep_state_t state_r;
    logic [3:0]   idx_r;
    logic         load_s;
    logic         run_s;
    logic         expire_s;
    logic [15:0]  tt_next_s;

    assign load_s    = (state_r == ST_IDLE) && start;
    assign run_s     = (state_r == ST_RUN);
    assign tt_next_s = tt_insert(truth_table, idx_r, o);

    // The vector index is the registered stimulus; a is its MSB, d its LSB.
    assign {a, b, c, d} = idx_r;

    sweep_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .run    (run_s),
        .expire (expire_s)
    );

    // Sweep FSM with registered status and capture outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 16'h0000;
            ones_count  <= 5'd0;
`ifdef LOGIC_SWEEP_COMPARE_EN
            pass        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r     <= ST_RUN;
                        idx_r       <= 4'd0;
                        busy        <= 1'b1;
                        truth_table <= 16'h0000;
                        ones_count  <= 5'd0;
`ifdef LOGIC_SWEEP_COMPARE_EN
                        pass        <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (expire_s) begin
                        truth_table <= tt_next_s;
                        ones_count  <= ones_count + {4'b0000, o};
                        // Index holds at 15 after the last sample instead of wrapping.
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`ifdef LOGIC_SWEEP_COMPARE_EN
                            pass    <= (tt_next_s == exp_tt) ? 1'b1 : 1'b0;
`endif
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_capture.sv
// Bench for logic_sweep_capture: an a&b DUT (SETTLE_CYC=1) and an a^b^c^d DUT
// (SETTLE_CYC=3), with expected sweep results queued at start and popped at done.
module tb_logic_sweep_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        a1, b1, c1, d1, busy1, done1, o1;
    logic        a3, b3, c3, d3, busy3, done3, o3;
    logic [15:0] tt1, tt3;
    logic [4:0]  oc1, oc3;
`ifdef LOGIC_SWEEP_COMPARE_EN
    logic [15:0] exp_tt1 = 16'h0000;
    logic [15:0] exp_tt3 = 16'h0000;
    logic        pass1, pass3;
`endif

    assign o1 = a1 & b1;
    assign o3 = a3 ^ b3 ^ c3 ^ d3;

    always #5 clk = ~clk;

    logic_sweep_capture #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .o(o1),
`ifdef LOGIC_SWEEP_COMPARE_EN
        .exp_tt(exp_tt1), .pass(pass1),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth_table(tt1), .ones_count(oc1)
    );

    logic_sweep_capture #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .o(o3),
`ifdef LOGIC_SWEEP_COMPARE_EN
        .exp_tt(exp_tt3), .pass(pass3),
`endif
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .truth_table(tt3), .ones_count(oc3)
    );

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;

    logic       done_m, busy_m;
    logic [3:0] vec_m;
    logic [15:0] tt_m;
    logic [4:0] oc_m;

    assign done_m = (cur == 1) ? done3 : done1;
    assign busy_m = (cur == 1) ? busy3 : busy1;
    assign vec_m  = (cur == 1) ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
    assign tt_m   = (cur == 1) ? tt3 : tt1;
    assign oc_m   = (cur == 1) ? oc3 : oc1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start3 = v;
        else          start1 = v;
    endtask

    function automatic exp_t make_exp(input int sel);
        exp_t       e;
        logic [3:0] v;
        logic       bv;
        e.tt   = 16'h0000;
        e.ones = 5'd0;
        e.lat  = (sel == 1) ? 16 * 3 : 16 * 1;
        for (int i = 0; i < 16; i++) begin
            v  = 4'(i);
            bv = (sel == 1) ? ^v : (v[3] & v[2]);
            e.tt[i] = bv;
            e.ones  = e.ones + {4'b0000, bv};
        end
        return e;
    endfunction

    // One sweep: accept, per-cycle vector hold check, done latency, result pop.
    task automatic sweep(input int sel, input bit keep_start, input int repulse_at);
        exp_t e;
        int   s;
        int   k;
        int   ei;
        cur = sel;
        s   = (sel == 1) ? 3 : 1;
        check("idle_before_start", 32'(busy_m), 32'd0);
        set_start(sel, 1'b1);
        tick;
        if (!keep_start) set_start(sel, 1'b0);
        check("busy_on_accept", 32'(busy_m), 32'd1);
        check("vec0_on_accept", 32'(vec_m), 32'd0);
        check("tt_cleared", 32'(tt_m), 32'd0);
        check("ones_cleared", 32'(oc_m), 32'd0);
        sb.push_back(make_exp(sel));
        for (k = 1; k <= 200; k++) begin
            if (repulse_at > 0) set_start(sel, (k == repulse_at * s + 1) ? 1'b1 : 1'b0);
            tick;
            ei = (k / s > 15) ? 15 : k / s;
            check("vector_hold", 32'(vec_m), 32'(ei));
            if (done_m) break;
        end
        if (repulse_at > 0) set_start(sel, 1'b0);
        check("sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_latency", 32'(k), 32'(e.lat));
            check("truth_table", 32'(tt_m), 32'(e.tt));
            check("ones_count", 32'(oc_m), 32'(e.ones));
        end
        check("busy_fall_at_done", 32'(busy_m), 32'd0);
        tick;
        check("done_single_cycle", 32'(done_m), 32'd0);
    endtask

    initial begin
        int dcount;
        #2 rst = 1'b1;
        #1;
        check("rst_async_vec1", 32'({a1, b1, c1, d1}), 32'd0);
        check("rst_async_busy1", 32'(busy1), 32'd0);
        check("rst_async_done1", 32'(done1), 32'd0);
        check("rst_async_tt1", 32'(tt1), 32'd0);
        check("rst_async_oc1", 32'(oc1), 32'd0);
        check("rst_async_tt3", 32'(tt3), 32'd0);
        repeat (2) tick;
        rst = 1'b0;
        tick;

        // a&b, settle 1
        sweep(0, 1'b0, 0);
        repeat (3) tick;
        check("idle_hold_tt", 32'(tt1), 32'hF000);
        check("idle_hold_oc", 32'(oc1), 32'd4);
        check("idle_hold_vec", 32'({a1, b1, c1, d1}), 32'hF);

        // parity, settle 3
        sweep(1, 1'b0, 0);

        // start re-pulsed at index 5 is ignored
        sweep(0, 1'b0, 5);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done1) dcount++;
        end
        check("repulse_no_extra_done", 32'(dcount), 32'd0);
        check("repulse_idle", 32'(busy1), 32'd0);

        // reset mid-sweep at index 7
        cur = 1;
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        repeat (21) tick;
        check("pre_rst_vec", 32'(vec_m), 32'd7);
        check("pre_rst_tt", 32'(tt3), 32'h0016);
        check("pre_rst_oc", 32'(oc3), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vec", 32'(vec_m), 32'd0);
        check("mid_rst_busy", 32'(busy3), 32'd0);
        check("mid_rst_done", 32'(done3), 32'd0);
        check("mid_rst_tt", 32'(tt3), 32'd0);
        check("mid_rst_oc", 32'(oc3), 32'd0);
        tick;
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (done3) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        sweep(1, 1'b0, 0);

`ifdef LOGIC_SWEEP_COMPARE_EN
        exp_tt1 = 16'hF000;
        sweep(0, 1'b0, 0);
        check("pass_match", 32'(pass1), 32'd1);
        tick;
        check("pass_held", 32'(pass1), 32'd1);
        exp_tt1 = 16'hF001;
        sweep(0, 1'b0, 0);
        check("pass_mismatch", 32'(pass1), 32'd0);
`endif

        // start tied high: back-to-back sweeps with one idle cycle between
        sweep(0, 1'b1, 0);
        sweep(0, 1'b1, 0);
        start1 = 1'b0;
        repeat (3) tick;
        check("b2b_stops_when_released", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/logic_sweep_capture.md
LOGIC_SWEEP_CAPTURE -- requirements
Module: logic_sweep_capture

Interface
REQ-001 Parameter SETTLE_CYC, default 1; cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset: asynchronous, active-high.
REQ-004 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-005 a, b, c, d  output  1 each  stimulus to the 4-input logic block under sweep; a is the MSB of the vector index, d the LSB.
REQ-006 o  input  1  response of the logic block under sweep.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  single-cycle pulse when a sweep completes.
REQ-009 truth_table  output  16  captured response; bit i = o observed for vector index i.
REQ-010 ones_count  output  5  number of set bits in truth_table, range 0..16.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the sample for index 15.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On accepting start, the block SHALL perform the following on that edge: clear truth_table and ones_count, set index=0, drive {a,b,c,d}=4'b0000, assert busy.
REQ-013 In RUN, each vector SHALL be held for exactly SETTLE_CYC cycles. o SHALL be sampled on the edge ending the hold period, into truth_table[index]. The next vector SHALL be driven on that same edge.
REQ-014 ones_count SHALL increment by 1 on each sample where o=1; it cannot overflow since the maximum is 16.
REQ-015 The vector index SHALL be a 4-bit counter stepping 0..15 in ascending order. It SHALL NOT wrap back to 0 within a sweep.
REQ-016 done SHALL be high exactly 16*SETTLE_CYC cycles after the start-accept edge, for exactly one cycle. busy SHALL fall in that same cycle.
REQ-017 start while in RUN or DONE SHALL be ignored, with no restart and no queueing.
REQ-018 start held high continuously SHALL begin a new sweep on the first cycle back in IDLE.
REQ-019 After DONE, truth_table and ones_count SHALL hold their values until the next start is accepted.
REQ-020 {a,b,c,d} SHALL hold the last driven vector (4'b1111) when idle after a sweep.

Reset
REQ-021 While rst=1, state SHALL be IDLE and a=b=c=d=0, busy=0, done=0, truth_table=16'h0000, ones_count=0. This applies immediately, regardless of clk.
REQ-022 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; partial results SHALL be discarded.
REQ-023 The first start accepted after rst deasserts SHALL be the first rising edge with start=1.

Configuration
REQ-024 With macro LOGIC_SWEEP_COMPARE_EN defined, the block SHALL add the following ports:
- input exp_tt[15:0].
- output pass[0:0], valid in the done cycle and held afterwards: pass = (truth_table == exp_tt), sampled at the end of the sweep; cleared on start and reset.
REQ-025 Without LOGIC_SWEEP_COMPARE_EN, exp_tt and pass SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-026 State encodings (IDLE/RUN/DONE) and the vector-count constant 16 SHALL live in the shared package logic_sweep_pkg.
REQ-027 The hold timer SHALL be a sub-module sweep_settle_timer: it loads SETTLE_CYC and emits a one-cycle expire pulse.
REQ-028 All other logic SHALL reside in logic_sweep_capture.

Verification
REQ-029 Bench model o=a&b, SETTLE_CYC=1, start pulse -> truth_table=16'hF000, ones_count=5'd4, done 16 cycles after the start edge.
REQ-030 Bench model o=a^b^c^d, SETTLE_CYC=3 -> truth_table=16'h6996, ones_count=5'd8, done 48 cycles after start; each vector held for 3 cycles.
REQ-031 rst pulsed at index 7 mid-sweep -> all outputs return to 0 asynchronously, no done; a subsequent start yields a full correct sweep.
REQ-032 start re-pulsed at index 5 -> ignored; the sweep completes normally with a single done pulse.
REQ-033 LOGIC_SWEEP_COMPARE_EN defined, o=a&b:
- exp_tt=16'hF000 -> pass=1 at done.
- exp_tt=16'hF001 -> pass=0 at done.
REQ-034 start tied high -> back-to-back sweeps, one IDLE cycle between DONE and the next start-accept edge; truth_table identical each sweep.
